// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order retirement path.
// Provides the register/tag/data widths, the number of register-file
// retirement write ports, and the packed entry type stored in the
// retire write queue.
package ooo_pkg;

    localparam int REG_AW     = 4;   // architectural register index width
    localparam int TAG_W      = 4;   // instruction tag (owner) width
    localparam int DATA_W     = 16;  // register value width
    localparam int NUM_WR     = 4;   // register-file write ports drained per cycle
    localparam int SLOT_CNT_W = $clog2(NUM_WR + 1);  // holds 0..NUM_WR

    // One retired result waiting to be written to the register file.
    typedef struct packed {
        logic              has_dest;  // 0 for stores/branches: occupies a slot, never writes
        logic [REG_AW-1:0] dest_reg;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } retire_entry_t;

endpackage

// File: rtl/retire_collision_mask.sv
// Youngest-wins write-enable mask for one drained group.
// Slot 0 is the oldest entry of the group. A slot is enabled when it is
// inside the group (index < k_i), carries a destination, and no younger
// slot in the group writes the same architectural register.
//
// Ports:
//   slot_i  in   NUM_WR x retire_entry_t  entries in drain order (0 = oldest)
//   k_i     in   SLOT_CNT_W               number of valid slots this cycle
//   mask_o  out  NUM_WR                   per-slot write enable
module retire_collision_mask
    import ooo_pkg::*;
(
    input  retire_entry_t [NUM_WR-1:0] slot_i,
    input  logic [SLOT_CNT_W-1:0]      k_i,
    output logic [NUM_WR-1:0]          mask_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_slot
            logic younger_hit;

            // Any younger in-group slot targeting the same register wins.
            always_comb begin
                younger_hit = 1'b0;
                for (int j = gi + 1; j < NUM_WR; j++) begin
                    if ((SLOT_CNT_W'(j) < k_i) && slot_i[j].has_dest &&
                        (slot_i[j].dest_reg == slot_i[gi].dest_reg)) begin
                        younger_hit = 1'b1;
                    end
                end
            end

            assign mask_o[gi] = (SLOT_CNT_W'(gi) < k_i) && slot_i[gi].has_dest && !younger_hit;
        end
    endgenerate

endmodule

// File: rtl/retire_write_scheduler.sv
// Retire write scheduler: buffers retired results in an in-order queue
// and drains up to NUM_WR of them per cycle onto the register file's
// retirement write ports. Inside a drained group only the youngest write
// to each register is enabled.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         retired-instruction handshake (in_ready = count < DEPTH)
//   in_has_dest, in_dest_reg,
//   in_data, in_tag             retired-instruction fields
//   rf_hold                     freeze the drain for this cycle
//   flush                       discard every queued entry (and the offered input)
//   wr_en/wr_reg/wr_data/wr_tag registered write-port outputs, one lane per port
//   retired_cnt                 entries drained at the last edge (0..NUM_WR)
//   occupancy                   current queue count (0..DEPTH)
module retire_write_scheduler
    import ooo_pkg::*;
#(
    parameter int DEPTH = 8   // must be a power of 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_has_dest,
    input  logic [REG_AW-1:0]               in_dest_reg,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic                            rf_hold,
    input  logic                            flush,
    output logic [NUM_WR-1:0]               wr_en,
    output logic [NUM_WR-1:0][REG_AW-1:0]   wr_reg,
    output logic [NUM_WR-1:0][DATA_W-1:0]   wr_data,
    output logic [NUM_WR-1:0][TAG_W-1:0]    wr_tag,
    output logic [SLOT_CNT_W-1:0]           retired_cnt,
    output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Queue storage and pointers
    retire_entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;

    // Registered write-port outputs
    logic [NUM_WR-1:0]              wr_en_q, wr_en_d;
    logic [NUM_WR-1:0][REG_AW-1:0]  wr_reg_q, wr_reg_d;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [NUM_WR-1:0][TAG_W-1:0]   wr_tag_q, wr_tag_d;
    logic [SLOT_CNT_W-1:0]          retired_cnt_q, retired_cnt_d;

    logic                       push;
    logic [SLOT_CNT_W-1:0]      k;
    retire_entry_t [NUM_WR-1:0] slot;
    logic [NUM_WR-1:0]          mask;
    retire_entry_t              in_entry;

    // Ready looks only at registered count, so a simultaneous drain never
    // opens a slot for a push when the queue is full.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    assign in_entry = '{has_dest: in_has_dest, dest_reg: in_dest_reg,
                        data: in_data, tag: in_tag};

    // Drain size for this cycle
    always_comb begin
        k = '0;
        if (!rf_hold && !flush) begin
            if (count_q >= CNT_W'(NUM_WR)) begin
                k = SLOT_CNT_W'(NUM_WR);
            end else begin
                k = SLOT_CNT_W'(count_q);
            end
        end
    end

    // Gather the group in age order; the pointer add wraps modulo DEPTH so a
    // group can straddle the end of the array.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_gather
            assign slot[gi] = mem_q[head_q + PTR_W'(gi)];
        end
    endgenerate

    retire_collision_mask u_mask (
        .slot_i (slot),
        .k_i    (k),
        .mask_o (mask)
    );

    // Next-state logic
    always_comb begin
        head_d        = head_q + PTR_W'(k);
        tail_d        = push ? tail_q + PTR_W'(1) : tail_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(k);
        wr_en_d       = mask;          // already zero when k == 0
        retired_cnt_d = k;
        wr_reg_d      = wr_reg_q;
        wr_data_d     = wr_data_q;
        wr_tag_d      = wr_tag_q;
        for (int i = 0; i < NUM_WR; i++) begin
            // Lanes outside the group keep their last fields.
            if (SLOT_CNT_W'(i) < k) begin
                wr_reg_d[i]  = slot[i].dest_reg;
                wr_data_d[i] = slot[i].data;
                wr_tag_d[i]  = slot[i].tag;
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            wr_en_q       <= '0;
            wr_reg_q      <= '0;
            wr_data_q     <= '0;
            wr_tag_q      <= '0;
            retired_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            wr_en_q       <= wr_en_d;
            wr_reg_q      <= wr_reg_d;
            wr_data_q     <= wr_data_d;
            wr_tag_q      <= wr_tag_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_reg      = wr_reg_q;
    assign wr_data     = wr_data_q;
    assign wr_tag      = wr_tag_q;
    assign retired_cnt = retired_cnt_q;
    assign occupancy   = count_q;

endmodule

// File: tb/tb_retire_write_scheduler.sv
// Directed testbench for retire_write_scheduler.
module tb_retire_write_scheduler;
    import ooo_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_has_dest;
    logic [REG_AW-1:0]              in_dest_reg;
    logic [DATA_W-1:0]              in_data;
    logic [TAG_W-1:0]               in_tag;
    logic                           rf_hold;
    logic                           flush;
    logic [NUM_WR-1:0]              wr_en;
    logic [NUM_WR-1:0][REG_AW-1:0]  wr_reg;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
    logic [NUM_WR-1:0][TAG_W-1:0]   wr_tag;
    logic [2:0]                     retired_cnt;
    logic [3:0]                     occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_write_scheduler #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_has_dest (in_has_dest),
        .in_dest_reg (in_dest_reg),
        .in_data     (in_data),
        .in_tag      (in_tag),
        .rf_hold     (rf_hold),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .wr_tag      (wr_tag),
        .retired_cnt (retired_cnt),
        .occupancy   (occupancy)
    );

    task automatic drive(input logic v, input logic hd, input logic [3:0] r,
                         input logic [15:0] d, input logic [3:0] t);
        in_valid    = v;
        in_has_dest = hd;
        in_dest_reg = r;
        in_data     = d;
        in_tag      = t;
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t occ=%0d rdy=%b wr_en=%b cnt=%0d data=%h_%h_%h_%h",
                 $time, occupancy, in_ready, wr_en, retired_cnt,
                 wr_data[3], wr_data[2], wr_data[1], wr_data[0]);
    endtask

    task automatic test_reset();
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en: got %b expected 0000", wr_en); end
        checks++; if (retired_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        tick();
        checks++; if (wr_en !== 4'b0000 || occupancy !== 4'd0) begin errors++; $display("FAIL idle: wr_en=%b occ=%0d expected 0000/0", wr_en, occupancy); end
    endtask

    task automatic test_push_sequence();
        drive(1, 1, 4'd1, 16'h0011, 4'd1); tick();
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL no_bypass: got %b expected 0000", wr_en); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL push1_occ: got %0d expected 1", occupancy); end
        drive(1, 1, 4'd2, 16'h0022, 4'd2); tick();
        checks++; if (wr_en !== 4'b0001 || retired_cnt !== 3'd1) begin errors++; $display("FAIL seq1_en: wr_en=%b cnt=%0d expected 0001/1", wr_en, retired_cnt); end
        checks++; if (wr_reg[0] !== 4'd1 || wr_data[0] !== 16'h0011 || wr_tag[0] !== 4'd1) begin errors++; $display("FAIL seq1_fields: reg=%0d data=%h tag=%0d expected 1/0011/1", wr_reg[0], wr_data[0], wr_tag[0]); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL seq1_occ: got %0d expected 1", occupancy); end
        drive(1, 1, 4'd3, 16'h0033, 4'd3); tick();
        checks++; if (wr_en !== 4'b0001 || wr_reg[0] !== 4'd2 || wr_data[0] !== 16'h0022 || wr_tag[0] !== 4'd2) begin errors++; $display("FAIL seq2: en=%b reg=%0d data=%h tag=%0d expected 0001/2/0022/2", wr_en, wr_reg[0], wr_data[0], wr_tag[0]); end
        drive(0, 0, 4'd0, 16'h0000, 4'd0); tick();
        checks++; if (wr_en !== 4'b0001 || wr_reg[0] !== 4'd3 || wr_data[0] !== 16'h0033 || wr_tag[0] !== 4'd3) begin errors++; $display("FAIL seq3: en=%b reg=%0d data=%h tag=%0d expected 0001/3/0033/3", wr_en, wr_reg[0], wr_data[0], wr_tag[0]); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL seq3_occ: got %0d expected 0", occupancy); end
        tick();
        checks++; if (wr_en !== 4'b0000 || retired_cnt !== 3'd0) begin errors++; $display("FAIL empty: wr_en=%b cnt=%0d expected 0000/0", wr_en, retired_cnt); end
        checks++; if (wr_data[0] !== 16'h0033) begin errors++; $display("FAIL empty_hold: data=%h expected 0033", wr_data[0]); end
    endtask

    task automatic test_collision();
        rf_hold = 1'b1;
        drive(1, 1, 4'd5, 16'hAAAA, 4'd4); tick();
        drive(1, 1, 4'd6, 16'h1234, 4'd5); tick();
        drive(1, 1, 4'd5, 16'hBBBB, 4'd6); tick();
        drive(1, 0, 4'd0, 16'h0000, 4'd7); tick();
        checks++; if (occupancy !== 4'd4 || wr_en !== 4'b0000) begin errors++; $display("FAIL hold: occ=%0d wr_en=%b expected 4/0000", occupancy, wr_en); end
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        rf_hold = 1'b0;
        tick();
        checks++; if (wr_en !== 4'b0110) begin errors++; $display("FAIL collide_en: got %b expected 0110", wr_en); end
        checks++; if (retired_cnt !== 3'd4) begin errors++; $display("FAIL collide_cnt: got %0d expected 4", retired_cnt); end
        checks++; if (wr_reg[2] !== 4'd5 || wr_data[2] !== 16'hBBBB || wr_tag[2] !== 4'd6) begin errors++; $display("FAIL collide_slot2: reg=%0d data=%h tag=%0d expected 5/BBBB/6", wr_reg[2], wr_data[2], wr_tag[2]); end
        checks++; if (wr_reg[1] !== 4'd6 || wr_data[1] !== 16'h1234 || wr_tag[1] !== 4'd5) begin errors++; $display("FAIL collide_slot1: reg=%0d data=%h tag=%0d expected 6/1234/5", wr_reg[1], wr_data[1], wr_tag[1]); end
        checks++; if (wr_data[0] !== 16'hAAAA || wr_tag[3] !== 4'd7) begin errors++; $display("FAIL collide_slot03: data0=%h tag3=%0d expected AAAA/7", wr_data[0], wr_tag[3]); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL collide_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_full();
        rf_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 4'(8 + i), 16'h0100 + 16'(i), 4'(i)); tick();
        end
        checks++; if (in_ready !== 1'b0 || occupancy !== 4'd8) begin errors++; $display("FAIL full: rdy=%b occ=%0d expected 0/8", in_ready, occupancy); end
        drive(1, 1, 4'd0, 16'hDEAD, 4'hF); tick();
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL drop9: occ=%0d expected 8", occupancy); end
        rf_hold = 1'b0;   // ninth entry still offered while full
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_drain_rdy: got %b expected 0", in_ready); end
        tick();
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        checks++; if (occupancy !== 4'd4 || wr_en !== 4'b1111 || retired_cnt !== 3'd4) begin errors++; $display("FAIL drainA: occ=%0d en=%b cnt=%0d expected 4/1111/4", occupancy, wr_en, retired_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_data[i] !== 16'h0100 + 16'(i) || wr_reg[i] !== 4'(8 + i)) begin errors++; $display("FAIL drainA_slot%0d: data=%h reg=%0d expected %h/%0d", i, wr_data[i], wr_reg[i], 16'h0100 + 16'(i), 8 + i); end
        end
        tick();
        checks++; if (occupancy !== 4'd0 || wr_en !== 4'b1111) begin errors++; $display("FAIL drainB: occ=%0d en=%b expected 0/1111", occupancy, wr_en); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_data[i] !== 16'h0104 + 16'(i) || wr_tag[i] !== 4'(4 + i)) begin errors++; $display("FAIL drainB_slot%0d: data=%h tag=%0d expected %h/%0d", i, wr_data[i], wr_tag[i], 16'h0104 + 16'(i), 4 + i); end
        end
        tick();
        checks++; if (wr_en !== 4'b0000 || occupancy !== 4'd0) begin errors++; $display("FAIL drop9_gone: en=%b occ=%0d expected 0000/0", wr_en, occupancy); end
    endtask

    task automatic test_flush();
        rf_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 4'(i), 16'h0200 + 16'(i), 4'(i)); tick();
        end
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL pre_flush_occ: got %0d expected 5", occupancy); end
        rf_hold = 1'b0;
        flush   = 1'b1;
        drive(1, 1, 4'd9, 16'hEEEE, 4'd9);
        tick();
        flush = 1'b0;
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        checks++; if (occupancy !== 4'd0 || wr_en !== 4'b0000 || retired_cnt !== 3'd0) begin errors++; $display("FAIL flush: occ=%0d en=%b cnt=%0d expected 0/0000/0", occupancy, wr_en, retired_cnt); end
        tick();
        checks++; if (occupancy !== 4'd0 || wr_en !== 4'b0000 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_drop: occ=%0d en=%b rdy=%b expected 0/0000/1", occupancy, wr_en, in_ready); end
    endtask

    task automatic test_wrap();
        // Head is at 0 after the flush; move it to 6.
        rf_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 4'(i), 16'h0300 + 16'(i), 4'(i)); tick();
        end
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        rf_hold = 1'b0;
        tick();
        tick();
        checks++; if (retired_cnt !== 3'd2 || wr_en !== 4'b0011 || occupancy !== 4'd0) begin errors++; $display("FAIL partial: cnt=%0d en=%b occ=%0d expected 2/0011/0", retired_cnt, wr_en, occupancy); end
        rf_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 4'(10 + i), 16'h0400 + 16'(i), 4'(8 + i)); tick();
        end
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        rf_hold = 1'b0;
        tick();
        checks++; if (wr_en !== 4'b1111 || occupancy !== 4'd1) begin errors++; $display("FAIL wrapA: en=%b occ=%0d expected 1111/1", wr_en, occupancy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_data[i] !== 16'h0400 + 16'(i) || wr_tag[i] !== 4'(8 + i)) begin errors++; $display("FAIL wrapA_slot%0d: data=%h tag=%0d expected %h/%0d", i, wr_data[i], wr_tag[i], 16'h0400 + 16'(i), 8 + i); end
        end
        tick();
        checks++; if (wr_en !== 4'b0001 || retired_cnt !== 3'd1 || wr_data[0] !== 16'h0404) begin errors++; $display("FAIL wrapB: en=%b cnt=%0d data=%h expected 0001/1/0404", wr_en, retired_cnt, wr_data[0]); end
        checks++; if (wr_data[1] !== 16'h0401) begin errors++; $display("FAIL wrapB_hold: data1=%h expected 0401", wr_data[1]); end
    endtask

    task automatic test_async_reset();
        rf_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 4'(i), 16'h0500 + 16'(i), 4'(i)); tick();
        end
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        rf_hold = 1'b0;
        tick();
        checks++; if (wr_en !== 4'b1111 || occupancy !== 4'd4) begin errors++; $display("FAIL pre_reset: en=%b occ=%0d expected 1111/4", wr_en, occupancy); end
        #2;
        rst_n = 1'b0;   // between edges
        #1;
        checks++; if (wr_en !== 4'b0000 || retired_cnt !== 3'd0 || occupancy !== 4'd0) begin errors++; $display("FAIL async_rst: en=%b cnt=%0d occ=%0d expected 0000/0/0", wr_en, retired_cnt, occupancy); end
        checks++; if (wr_data[0] !== 16'h0000 || wr_reg[3] !== 4'd0 || wr_tag[2] !== 4'd0) begin errors++; $display("FAIL async_rst_fields: data0=%h reg3=%0d tag2=%0d expected 0/0/0", wr_data[0], wr_reg[3], wr_tag[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (wr_en !== 4'b0000 || occupancy !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_rst: en=%b occ=%0d rdy=%b expected 0000/0/1", wr_en, occupancy, in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rf_hold = 1'b0;
        flush   = 1'b0;
        drive(0, 0, 4'd0, 16'h0000, 4'd0);
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_push_sequence();
        test_collision();
        test_full();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
